div_unit: RTL and testbench
===========================

# div_unit

Multicycle signed 32-bit integer divider for the MIPS datapath, sitting directly downstream of the control unit. It consumes the control unit's `divControl` start request and the A/B register operands. It returns the quotient and remainder for the HI/LO registers, plus the `divZero` exception flag that the control unit uses to branch to the exception sequence. It uses a restoring shift-subtract algorithm, one quotient bit per cycle.

## Interface
- `WIDTH`, default 32: operand and result width. Only 32 is supported and verified.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state on the next rising edge.
- `divControl`  in  1  start request; sampled on the rising edge when `busy`=0.
- `a`  in  32  dividend, signed two's complement; sampled with the start request.
- `b`  in  32  divisor, signed two's complement; sampled with the start request.
- `hi`  out  32  remainder; registered, holds its value until the next successful divide.
- `lo`  out  32  quotient; registered, holds its value until the next successful divide.
- `busy`  out  1  high while a divide is in progress (states CALC and FIX).
- `done`  out  1  one-cycle pulse; `hi`/`lo` are valid in this cycle.
- `divZero`  out  1  one-cycle pulse when the divisor was zero.

## Operation
- The state machine has five states: IDLE, CALC, FIX, DONE and ZERO.
- **IDLE / DONE:**
  - If `divControl`=1 and `b`=0, go to ZERO.
  - If `divControl`=1 and `b`≠0:
    - Latch sign flags `sa`=`a[31]` and `sb`=`b[31]`.
    - Latch the magnitudes `|a|` and `|b|` as 32-bit unsigned values (`|0x80000000|` = `0x80000000`).
    - Clear the 33-bit partial remainder `r` and the 6-bit counter `cnt`.
    - Go to CALC.
  - Otherwise, IDLE stays in IDLE and DONE returns to IDLE.
- **CALC:** one step per cycle.
  - Form `r' = {r[31:0], q[31]}` and shift `q` left by 1.
  - If `r'` ≥ `{0,|b|}`, then `r = r' - |b|` and `q[0] = 1`; else `r = r'` and `q[0] = 0`.
  - Increment `cnt`; after the step with `cnt`=31, go to FIX.
- **FIX:**
  - `lo` = `(sa^sb) ? -q : q`.
  - `hi` = `sa ? -r[31:0] : r[31:0]`.
  - Go to DONE.
- **ZERO:**
  - `divZero`=1 for this cycle; `hi` and `lo` are not written; `done` is not asserted.
  - Go to IDLE.
- **Semantics:** MIPS `div`. The quotient truncates toward zero. The remainder takes the sign of the dividend and satisfies `a = lo*b + hi`.
- **Overflow case** `a`=`0x80000000`, `b`=`0xFFFFFFFF`:
  - Result is `lo`=`0x80000000`, `hi`=0.
  - No flag is raised.
- `divControl` while `busy`=1 is ignored. The in-flight operation and its latched operands are unaffected.
- Changes on `a` or `b` after the start edge have no effect.

## Timing
- **Reset values:** `hi`=0, `lo`=0, `busy`=0, `done`=0, `divZero`=0; state IDLE; counter and internal registers 0.
- **Reset mid-operation:** aborts on the next edge. `hi` and `lo` are cleared to 0 and no `done` is produced.
- **Latency:** start sampled at the edge ending cycle 0.
  - `busy`=1 in cycles 1–33.
  - CALC occupies cycles 1–32.
  - FIX occupies cycle 33.
  - `done`=1 in cycle 34, with the new `hi`/`lo` visible from cycle 34 onward.
- **Back-to-back:** a new start is accepted in the `done` cycle (cycle 34), giving a 34-cycle issue interval.
- **Divide by zero:** `divZero`=1 in cycle 1 only and `busy` stays 0. A new start is accepted from cycle 2.
- Reset has priority over `divControl` in the same cycle.

## Test plan
- Reset, then `a`=100, `b`=7, pulse `divControl`:
  - `busy` is high in cycles 1–33.
  - `done` is high in cycle 34 with `lo`=14, `hi`=2.
  - `done` is low in cycle 35.
- Sign combinations:
  - `a`=-100, `b`=7 gives `lo`=-14 (`0xFFFFFFF2`), `hi`=-2.
  - `a`=100, `b`=-7 gives `lo`=-14, `hi`=2.
  - `a`=-100, `b`=-7 gives `lo`=14, `hi`=-2.
- Extremes:
  - `a`=`0x80000000`, `b`=`0xFFFFFFFF` gives `lo`=`0x80000000`, `hi`=0.
  - `a`=5, `b`=`0x80000000` gives `lo`=0, `hi`=5.
  - `a`=`0x7FFFFFFF`, `b`=1 gives `lo`=`0x7FFFFFFF`, `hi`=0.
- Divide by zero:
  - Set previous `hi`/`lo` to 2/14, then send `b`=0 with `divControl`.
  - Expect `divZero`=1 in cycle 1 only, `done` never asserted, `busy`=0, `hi`/`lo` still 2/14.
- Start ignored while busy:
  - Start 100/7; in cycle 10, pulse `divControl` with `a`=9, `b`=3.
  - The result is still 14/2 in cycle 34, and exactly one `done` pulse occurs.
- Reset mid-operation:
  - Assert `reset` in cycle 15 of a divide.
  - From the next cycle: `busy`=0, `hi`=`lo`=0, and no `done` pulse.
  - A subsequent 100/7 completes correctly with 34-cycle latency.

Source files
------------

// File: rtl/div_unit.sv
// Signed restoring divider for the MIPS HI/LO path.
// One quotient bit per cycle; sign fix-up applied in a final cycle.
`timescale 1ns/1ps
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             divControl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             divZero
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE,
    S_ZERO
  } state_t;

  state_t           r_state;
  logic             r_sa;
  logic             r_sb;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_r;
  logic [5:0]       r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;
  logic             r_zero;

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;
  logic             w_last;

  assign w_abs_a = a[WIDTH-1] ? -a : a;
  assign w_abs_b = b[WIDTH-1] ? -b : b;
  assign w_shift = {r_r, r_q[WIDTH-1]};
  assign w_ge    = w_shift >= {1'b0, r_b};
  // Remainder after subtract is below |b|, so it fits in WIDTH bits.
  assign w_sub   = w_shift[WIDTH-1:0] - r_b;
  assign w_last  = r_cnt == 6'(WIDTH - 1);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_q     <= '0;
      r_b     <= '0;
      r_r     <= '0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_zero <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          if (divControl) begin
            if (b == '0) begin
              r_state <= S_ZERO;
              r_zero  <= 1'b1;
            end else begin
              r_state <= S_CALC;
              r_busy  <= 1'b1;
              r_sa    <= a[WIDTH-1];
              r_sb    <= b[WIDTH-1];
              r_q     <= w_abs_a;
              r_b     <= w_abs_b;
              r_r     <= '0;
              r_cnt   <= '0;
            end
          end
        end
        S_CALC: begin
          r_q   <= {r_q[WIDTH-2:0], w_ge};
          r_r   <= w_ge ? w_sub : w_shift[WIDTH-1:0];
          r_cnt <= r_cnt + 6'd1;
          if (w_last) r_state <= S_FIX;
        end
        S_FIX: begin
          r_lo    <= (r_sa ^ r_sb) ? -r_q : r_q;
          r_hi    <= r_sa ? -r_r : r_r;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_ZERO: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign hi      = r_hi;
  assign lo      = r_lo;
  assign busy    = r_busy;
  assign done    = r_done;
  assign divZero = r_zero;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected HI/LO,
// a negedge monitor pops and compares on every done pulse.
`timescale 1ns/1ps
module tb_div_unit;

  logic        clock;
  logic        reset;
  logic        divControl;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        divZero;

  div_unit #(.WIDTH(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .divControl (divControl),
    .a          (a),
    .b          (b),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .divZero    (divZero)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   n_vec  = 0;
  int   n_err  = 0;
  int   n_zero = 0;
  int   cyc    = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (done) begin
        if (sbq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got hi=%h lo=%h want no done",
                   hi, lo);
        end else begin
          e = sbq.pop_front();
          chk("lo", lo, e.lo);
          chk("hi", hi, e.hi);
          chk("done_cycle", cyc, e.cyc);
        end
      end
      if (divZero) n_zero++;
    end
  end

  // Called right after a negedge; operands scrambled after the start edge.
  task automatic start(input logic [31:0] va, vb,
                       input bit push,
                       input logic [31:0] ehi, elo);
    a = va;
    b = vb;
    divControl = 1'b1;
    @(posedge clock);
    #1;
    divControl = 1'b0;
    a = $urandom;
    b = $urandom;
    if (push) sbq.push_back('{ehi, elo, cyc + 33});
  endtask

  // Returns at the negedge of the done cycle (cycle 34).
  task automatic run_op(input logic [31:0] va, vb, ehi, elo);
    int bad;
    bad = 0;
    start(va, vb, 1'b1, ehi, elo);
    for (int k = 1; k <= 33; k++) begin
      @(negedge clock);
      if (busy !== 1'b1 || done !== 1'b0) bad++;
    end
    chk("busy_window", bad, 0);
    @(negedge clock);
    chk("busy_at_done", {31'b0, busy}, 0);
  endtask

  initial begin
    reset = 1'b1;
    divControl = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_zero", {31'b0, divZero}, 0);

    run_op(100, 7, 2, 14);
    @(negedge clock);
    chk("done_low_c35", {31'b0, done}, 0);

    // Back-to-back issues, each started in the previous done cycle.
    run_op(-100, 7, -2, -14);
    run_op(100, -7, 2, -14);
    run_op(-100, -7, -2, 14);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000);
    run_op(5, 32'h8000_0000, 5, 0);
    run_op(32'h7FFF_FFFF, 1, 0, 32'h7FFF_FFFF);
    run_op(100, 7, 2, 14);

    start(32'd55, 32'd0, 1'b0, 0, 0);
    @(negedge clock);
    chk("dz_c1_flag", {31'b0, divZero}, 1);
    chk("dz_c1_busy", {31'b0, busy}, 0);
    @(negedge clock);
    chk("dz_c2_flag", {31'b0, divZero}, 0);
    chk("dz_hi_kept", hi, 2);
    chk("dz_lo_kept", lo, 14);
    chk("dz_busy", {31'b0, busy}, 0);

    start(100, 7, 1'b1, 2, 14);
    for (int k = 1; k <= 33; k++) begin
      @(negedge clock);
      if (k == 10) begin
        a = 9;
        b = 3;
        divControl = 1'b1;
      end else begin
        divControl = 1'b0;
      end
    end
    @(negedge clock);
    @(negedge clock);

    start(100, 7, 1'b0, 0, 0);
    repeat (15) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_busy", {31'b0, busy}, 0);
    chk("mid_rst_hi", hi, 0);
    chk("mid_rst_lo", lo, 0);
    reset = 1'b0;
    repeat (40) @(negedge clock);

    run_op(100, 7, 2, 14);
    repeat (3) @(negedge clock);
    chk("sb_empty", sbq.size(), 0);
    chk("zero_pulses", n_zero, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
